// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM/WB register-usage inputs and the stall/flush/forward controls.
// The master side is the pipeline datapath and the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_re1;
  logic       id_re2;
  logic [4:0] ex_wR;
  logic       ex_we_rf;
  logic [2:0] ex_wd_sel;
  logic [4:0] mem_wR;
  logic       mem_we_rf;
  logic [4:0] wb_wR;
  logic       wb_we_rf;
  logic       ex_br_taken;
  logic       stall_pc;
  logic       stall_if_id;
  logic       stall;
  logic       flush_if_id;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [2:0] busy_cnt;

  modport master (
    output id_rs1, id_rs2, id_re1, id_re2, ex_wR, ex_we_rf, ex_wd_sel,
           mem_wR, mem_we_rf, wb_wR, wb_we_rf, ex_br_taken,
    input  stall_pc, stall_if_id, stall, flush_if_id, fwd_a, fwd_b, busy_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_re1, id_re2, ex_wR, ex_we_rf, ex_wd_sel,
           mem_wR, mem_we_rf, wb_wR, wb_we_rf, ex_br_taken,
    output stall_pc, stall_if_id, stall, flush_if_id, fwd_a, fwd_b, busy_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard scheduler: operand forwarding, load-use stalls and taken-branch flush.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter logic [2:0]  WD_SEL_DRAM    = 3'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_events,
    output logic [31:0]          flush_events
`endif
);

    typedef enum logic {IDLE, LSTALL} state_t;

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYC - 1);

    state_t          state;
    logic [2:0]      cnt_q;
    logic [1:0][4:0] rs;
    logic [1:0]      re;
    logic [1:0][1:0] fwd_sel;
    logic [1:0]      ex_hit;
    logic            ex_load;
    logic            load_use;

    assign rs      = {hz.id_rs2, hz.id_rs1};
    assign re      = {hz.id_re2, hz.id_re1};
    assign ex_load = (hz.ex_wd_sel == WD_SEL_DRAM);

    // One match/priority slice per source operand; x0 never matches.
    for (genvar i = 0; i < 2; i++) begin : g_op
        logic used, hit_ex, hit_mem, hit_wb;
        assign used    = re[i] & (rs[i] != 5'd0);
        assign hit_ex  = used & hz.ex_we_rf  & (hz.ex_wR  == rs[i]);
        assign hit_mem = used & hz.mem_we_rf & (hz.mem_wR == rs[i]);
        assign hit_wb  = used & hz.wb_we_rf  & (hz.wb_wR  == rs[i]);
        assign ex_hit[i]  = hit_ex;
        assign fwd_sel[i] = (hit_ex & ~ex_load) ? 2'd1 :
                            hit_mem             ? 2'd2 :
                            hit_wb              ? 2'd3 : 2'd0;
    end

    assign load_use = ex_load & (|ex_hit);

    always_comb begin
        hz.stall_pc    = 1'b0;
        hz.stall_if_id = 1'b0;
        hz.stall       = 1'b0;
        hz.flush_if_id = 1'b0;
        hz.fwd_a       = 2'd0;
        hz.fwd_b       = 2'd0;
        hz.busy_cnt    = 3'd0;
        if (!rst) begin
            hz.fwd_a    = fwd_sel[0];
            hz.fwd_b    = fwd_sel[1];
            hz.busy_cnt = cnt_q;
            // A taken branch in EX always wins: the ID instruction is wrong-path.
            if (hz.ex_br_taken) begin
                hz.flush_if_id = 1'b1;
                hz.stall       = 1'b1;
            end else if (state == LSTALL || load_use) begin
                hz.stall_pc    = 1'b1;
                hz.stall_if_id = 1'b1;
                hz.stall       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt_q <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hz.ex_br_taken && load_use && LOAD_STALL_CYC > 1) begin
                        state <= LSTALL;
                        cnt_q <= STALL_INIT;
                    end
                end
                LSTALL: begin
                    if (hz.ex_br_taken || cnt_q <= 3'd1) begin
                        state <= IDLE;
                        cnt_q <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt_q <= 3'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Branch bubbles also raise stall; only load-caused stall cycles count here.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_events <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (hz.stall && !hz.flush_if_id && stall_events != 32'hFFFF_FFFF)
                stall_events <= stall_events + 32'd1;
            if (hz.flush_if_id && flush_events != 32'hFFFF_FFFF)
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: single-cycle (u1) and three-cycle (u3) load-stall controllers on shared stimulus.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl_if if1 ();
    pipeline_hazard_ctrl_if if3 ();

    assign if3.id_rs1      = if1.id_rs1;
    assign if3.id_rs2      = if1.id_rs2;
    assign if3.id_re1      = if1.id_re1;
    assign if3.id_re2      = if1.id_re2;
    assign if3.ex_wR       = if1.ex_wR;
    assign if3.ex_we_rf    = if1.ex_we_rf;
    assign if3.ex_wd_sel   = if1.ex_wd_sel;
    assign if3.mem_wR      = if1.mem_wR;
    assign if3.mem_we_rf   = if1.mem_we_rf;
    assign if3.wb_wR       = if1.wb_wR;
    assign if3.wb_we_rf    = if1.wb_we_rf;
    assign if3.ex_br_taken = if1.ex_br_taken;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] se1, fe1, se3, fe3;
    pipeline_hazard_ctrl #(.LOAD_STALL_CYC(1)) u1 (.clk(clk), .rst(rst), .hz(if1),
        .stall_events(se1), .flush_events(fe1));
    pipeline_hazard_ctrl #(.LOAD_STALL_CYC(3)) u3 (.clk(clk), .rst(rst), .hz(if3),
        .stall_events(se3), .flush_events(fe3));
`else
    pipeline_hazard_ctrl #(.LOAD_STALL_CYC(1)) u1 (.clk(clk), .rst(rst), .hz(if1));
    pipeline_hazard_ctrl #(.LOAD_STALL_CYC(3)) u3 (.clk(clk), .rst(rst), .hz(if3));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       re1, re2;
        logic [4:0] ex_wR;
        logic       ex_we;
        logic [2:0] ex_sel;
        logic [4:0] mem_wR;
        logic       mem_we;
        logic [4:0] wb_wR;
        logic       wb_we;
        logic       br;
        logic [3:0] exp_ctl;   // {stall_pc, stall_if_id, stall, flush_if_id}
        logic [1:0] exp_a, exp_b;
    } vec_t;

    function automatic vec_t mk(int rs1, int rs2, int re1, int re2, int exw, int exwe, int exsel,
                                int memw, int memwe, int wbw, int wbwe, int br,
                                int ctl, int a, int b);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.re1 = 1'(re1); v.re2 = 1'(re2);
        v.ex_wR = 5'(exw); v.ex_we = 1'(exwe); v.ex_sel = 3'(exsel);
        v.mem_wR = 5'(memw); v.mem_we = 1'(memwe);
        v.wb_wR = 5'(wbw); v.wb_we = 1'(wbwe); v.br = 1'(br);
        v.exp_ctl = 4'(ctl); v.exp_a = 2'(a); v.exp_b = 2'(b);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        if1.id_rs1 = v.rs1;     if1.id_rs2 = v.rs2;
        if1.id_re1 = v.re1;     if1.id_re2 = v.re2;
        if1.ex_wR = v.ex_wR;    if1.ex_we_rf = v.ex_we;   if1.ex_wd_sel = v.ex_sel;
        if1.mem_wR = v.mem_wR;  if1.mem_we_rf = v.mem_we;
        if1.wb_wR = v.wb_wR;    if1.wb_we_rf = v.wb_we;
        if1.ex_br_taken = v.br;
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic int ctl1();
        return {if1.stall_pc, if1.stall_if_id, if1.stall, if1.flush_if_id};
    endfunction

    function automatic int ctl3();
        return {if3.stall_pc, if3.stall_if_id, if3.stall, if3.flush_if_id};
    endfunction

    vec_t idle_v;
    vec_t vecs[17];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(idle_v);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle_v = mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0, 0,0,0);
        //           rs1 rs2 re1 re2 exW we sel memW we wbW we br  ctl     a b
        vecs[0]  = mk(0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[1]  = mk(5, 0, 1, 0,  5, 1, 0,  5, 1,  0, 0, 0, 4'b0000, 1, 0);
        vecs[2]  = mk(5, 0, 1, 0,  5, 0, 0,  5, 1,  0, 0, 0, 4'b0000, 2, 0);
        vecs[3]  = mk(0, 0, 1, 0,  0, 1, 0,  0, 1,  0, 1, 0, 4'b0000, 0, 0);
        vecs[4]  = mk(5, 0, 0, 0,  5, 1, 0,  5, 1,  5, 1, 0, 4'b0000, 0, 0);
        vecs[5]  = mk(0, 9, 0, 1,  0, 0, 0,  0, 0,  9, 1, 0, 4'b0000, 0, 3);
        vecs[6]  = mk(0, 9, 0, 1,  0, 0, 0,  9, 1,  9, 1, 0, 4'b0000, 0, 2);
        vecs[7]  = mk(0, 7, 0, 1,  7, 1, 1,  0, 0,  0, 0, 0, 4'b1110, 0, 0);
        vecs[8]  = mk(0, 7, 0, 1,  7, 1, 1,  7, 1,  0, 0, 0, 4'b1110, 0, 2);
        vecs[9]  = mk(0, 7, 0, 1,  0, 0, 0,  7, 1,  0, 0, 0, 4'b0000, 0, 2);
        vecs[10] = mk(0, 7, 0, 0,  7, 1, 1,  0, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[11] = mk(7, 3, 1, 1,  7, 1, 1,  0, 0,  3, 1, 0, 4'b1110, 0, 3);
        vecs[12] = mk(0, 7, 0, 1,  7, 1, 1,  0, 0,  0, 0, 1, 4'b0011, 0, 0);
        vecs[13] = mk(0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 1, 4'b0011, 0, 0);
        vecs[14] = mk(0, 7, 0, 1,  7, 0, 1,  0, 0,  0, 0, 0, 4'b0000, 0, 0);
        vecs[15] = mk(4, 4, 1, 1,  4, 1, 0,  4, 1,  4, 1, 0, 4'b0000, 1, 1);
        vecs[16] = mk(0, 7, 0, 1,  7, 1, 2,  0, 0,  0, 0, 0, 4'b0000, 0, 1);

        // Reset dominates: branch + load-use + WB forward pending, all outputs must read 0.
        rst = 1'b1;
        drive(mk(7,3,1,1, 7,1,1, 0,0, 3,1, 1, 0,0,0));
        #2;
        chk("rst_ctl1", 0, ctl1(), 0);
        chk("rst_fwd_a1", 0, if1.fwd_a, 0);
        chk("rst_fwd_b1", 0, if1.fwd_b, 0);
        chk("rst_busy1", 0, if1.busy_cnt, 0);
        chk("rst_ctl3", 0, ctl3(), 0);
        chk("rst_busy3", 0, if3.busy_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(idle_v);
        #1;
        chk("post_rst_busy3", 0, if3.busy_cnt, 0);
        chk("post_rst_ctl3", 0, ctl3(), 0);

        // Combinational vectors on the single-cycle controller (never leaves IDLE).
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("vec_ctl", i, ctl1(), vecs[i].exp_ctl);
            chk("vec_fwd_a", i, if1.fwd_a, vecs[i].exp_a);
            chk("vec_fwd_b", i, if1.fwd_b, vecs[i].exp_b);
        end

        // Single-cycle load-use: stall in detect cycle, load forwarded from MEM next cycle.
        do_reset();
        drive(vecs[7]);
        #1;
        chk("lu1_stall", 0, ctl1(), 4'b1110);
        @(negedge clk);
        drive(vecs[9]);
        #1;
        chk("lu1_release", 1, ctl1(), 0);
        chk("lu1_fwd_b", 1, if1.fwd_b, 2);

        // Three-cycle load-use on u3: busy 0 (detect), 2, 1, then idle.
        do_reset();
        drive(vecs[7]);
        #1;
        chk("lu3_ctl", 0, ctl3(), 4'b1110);
        chk("lu3_busy", 0, if3.busy_cnt, 0);
        @(negedge clk);
        drive(vecs[9]);
        #1;
        chk("lu3_ctl", 1, ctl3(), 4'b1110);
        chk("lu3_busy", 1, if3.busy_cnt, 2);
        chk("lu3_fwd_b", 1, if3.fwd_b, 2);
        @(negedge clk);
        drive(idle_v);
        #1;
        chk("lu3_ctl", 2, ctl3(), 4'b1110);
        chk("lu3_busy", 2, if3.busy_cnt, 1);
        @(negedge clk);
        #1;
        chk("lu3_ctl", 3, ctl3(), 0);
        chk("lu3_busy", 3, if3.busy_cnt, 0);

        // Older branch resolves while u3 is mid-stall: abort and flush.
        do_reset();
        drive(vecs[7]);
        @(negedge clk);
        drive(vecs[13]);
        #1;
        chk("abort_busy", 0, if3.busy_cnt, 2);
        chk("abort_ctl", 0, ctl3(), 4'b0011);
        @(negedge clk);
        drive(idle_v);
        #1;
        chk("abort_ctl", 1, ctl3(), 0);
        chk("abort_busy", 1, if3.busy_cnt, 0);

        // Branch and load-use together: flush wins, no stall sequence follows.
        do_reset();
        drive(vecs[12]);
        #1;
        chk("br_lu_ctl", 0, ctl3(), 4'b0011);
        @(negedge clk);
        drive(idle_v);
        #1;
        chk("br_lu_ctl", 1, ctl3(), 0);
        chk("br_lu_busy", 1, if3.busy_cnt, 0);

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        #1;
        chk("perf_clr_stall", 0, se1, 0);
        chk("perf_clr_flush", 0, fe1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(vecs[7]);
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            drive(vecs[13]);
            @(negedge clk);
        end
        drive(idle_v);
        #1;
        chk("perf_stall", 1, se1, 3);
        chk("perf_flush", 1, fe1, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
